// File: rtl/legv8_multicycle_control_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: states, instruction
// classes, AluOp codes, trap causes and opcode match patterns.
package legv8_multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_I    = 3'd2,
    CL_LDUR = 3'd3,
    CL_STUR = 3'd4,
    CL_CBZ  = 3'd5,
    CL_B    = 3'd6
  } class_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_I    = 11'b11111111110;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/legv8_multicycle_control_opcode_class.sv
// Combinational opcode classifier; shared with the single-cycle decoder.
module legv8_opcode_class
  import legv8_multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output class_e      op_class,
  output logic        illegal
);

  always_comb begin
    op_class = CL_NONE;
    if      (op_match(opcode, OP_LDUR, MASK_FULL)) op_class = CL_LDUR;
    else if (op_match(opcode, OP_STUR, MASK_FULL)) op_class = CL_STUR;
    else if (op_match(opcode, OP_CBZ,  MASK_CBZ))  op_class = CL_CBZ;
    else if (op_match(opcode, OP_B,    MASK_B))    op_class = CL_B;
    else if (op_match(opcode, OP_ADD,  MASK_FULL) || op_match(opcode, OP_SUB, MASK_FULL) ||
             op_match(opcode, OP_AND,  MASK_FULL) || op_match(opcode, OP_ORR, MASK_FULL))
      op_class = CL_R;
    else if (op_match(opcode, OP_ADDI, MASK_I) || op_match(opcode, OP_SUBI, MASK_I))
      op_class = CL_I;
    illegal = (op_class == CL_NONE);
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, holds memory
// requests until mem_ready, traps on illegal opcode or memory timeout, counts retirements.
module legv8_multicycle_control
  import legv8_multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

  state_e             state_q, state_d;
  class_e             class_q, class_d, dec_cls;
  logic               dec_ill;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [1:0]         aluop;
  logic               tmo, retire;

  legv8_opcode_class u_class (
    .opcode   (11'(opcode)),
    .op_class (dec_cls),
    .illegal  (dec_ill)
  );

  // A ready in the cycle that would hit the limit still completes the access.
  assign tmo = (TIMEOUT != 0) && !mem_ready && ((wait_q + 1'b1) == WAIT_LIM);

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    wait_d   = wait_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    aluop    = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TMO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        Reg2Loc = (dec_cls == CL_STUR) || (dec_cls == CL_CBZ);
        class_d = dec_cls;
        if (dec_ill) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUSrc = (class_q == CL_LDUR) || (class_q == CL_STUR) || (class_q == CL_I);
        case (class_q)
          CL_B: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CL_CBZ: begin
            aluop   = ALU_PASSB;
            PCWrite = zero;
            PCSrc   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CL_LDUR, CL_STUR: state_d = ST_MEM;
          default: begin
            aluop   = ALU_FUNCT;
            state_d = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (class_q == CL_LDUR);
        MemWrite = (class_q == CL_STUR);
        if (mem_ready) begin
          retire  = (class_q == CL_STUR);
          state_d = (class_q == CL_STUR) ? ST_FETCH : ST_WB;
        end else if (tmo) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TMO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (class_q == CL_LDUR);
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      default: ;
    endcase
    // Every transition lands in a different state, so this covers entry to FETCH and MEM.
    if (state_d != state_q) wait_d = '0;
    retired_d = retire ? retired_q + 1'b1 : retired_q;
    if (reset) begin
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      aluop    = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_NONE;
      wait_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  assign AluOp      = ALUOP_W'(aluop);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule
